// File: rtl/fpu_normalize_round_if.sv
// Handshake bundle for fpu_normalize_round: the upstream beat (in_*) and the packed result.
interface fpu_normalize_round_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int IN_W = 2*MAN_W+2;

    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [EXP_W-1:0]   in_exponent;
    logic [IN_W-1:0]    in_mantissa;
    logic [1:0]         in_operator;
    logic               out_valid;
    logic               out_ready;
    logic               sign;
    logic [EXP_W-1:0]   exponent;
    logic [MAN_W-1:0]   mantissa;
    logic [3:0]         flags;

    modport master (
        output in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
        input  in_ready, out_valid, sign, exponent, mantissa, flags
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_mantissa, in_operator, out_ready,
        output in_ready, out_valid, sign, exponent, mantissa, flags
    );
endinterface

// File: rtl/fpu_normalize_round.sv
// Two-stage normalise (s1) and round/pack (s2) pipeline with valid/ready flow control.
// FPU_NORM_ROUND_EN selects round-to-nearest-even with a live inexact flag; otherwise truncate.
module fpu_normalize_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpu_normalize_round_if.slave  bus
);
    localparam int IN_W = 2*MAN_W+2;
    localparam int XW   = EXP_W+2;
    localparam int LZ_W = $clog2(IN_W);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);
`ifdef FPU_NORM_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic                  r_s1Valid;
    logic                  r_s1Sign;
    logic signed [XW-1:0]  r_s1Exp;
    logic [IN_W-3:0]       r_s1Man;
    logic                  r_s1Sticky;
    logic                  r_s1Zero;
    logic                  r_s1MulUnf;
    logic                  r_s1Rsvd;

    logic                  r_outValid;
    logic                  r_sign;
    logic [EXP_W-1:0]      r_exp;
    logic [MAN_W-1:0]      r_man;
    logic [3:0]            r_flags;

    logic                  w_s2Load;
    logic                  w_s1Load;
    logic [LZ_W-1:0]       w_lz;
    logic                  w_carry;
    logic                  w_nonzero;
    logic                  w_shiftOut;
    logic                  w_mulUnf;
    logic [IN_W-3:0]       w_norm;
    logic signed [XW-1:0]  w_normExp;

    logic [MAN_W-1:0]      w_kept;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_inc;
    logic                  w_inexact;
    logic [MAN_W:0]        w_sum;
    logic signed [XW-1:0]  w_rndExp;
    logic                  w_sign;
    logic [EXP_W-1:0]      w_exp;
    logic [MAN_W-1:0]      w_man;
    logic [3:0]            w_flags;

    // No skid buffer: s1 can only take a beat if it is empty or moving into s2 this cycle.
    assign w_s2Load     = !r_outValid || bus.out_ready;
    assign w_s1Load     = !r_s1Valid || w_s2Load;
    assign bus.in_ready = rst_n && w_s1Load;

    always_comb begin
        w_lz = '0;
        for (int i = 0; i < IN_W-1; i++) begin
            if (bus.in_mantissa[i]) begin
                w_lz = LZ_W'(IN_W-2-i);
            end
        end
    end

    assign w_carry   = bus.in_mantissa[IN_W-1];
    assign w_nonzero = |bus.in_mantissa;
    assign w_mulUnf  = (bus.in_operator == 2'b10) && !w_carry && w_nonzero && (w_lz > LZ_W'(1));

    // Only the bits below the hidden one are kept; the hidden bit is implied from here on.
    always_comb begin
        w_norm     = (IN_W-2)'(bus.in_mantissa << w_lz);
        w_normExp  = $signed(XW'(bus.in_exponent)) - $signed(XW'(w_lz));
        w_shiftOut = 1'b0;
        if (w_carry) begin
            w_norm     = bus.in_mantissa[IN_W-2:1];
            w_normExp  = $signed(XW'(bus.in_exponent)) + EXP_ONE;
            w_shiftOut = bus.in_mantissa[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1Exp    <= '0;
            r_s1Man    <= '0;
            r_s1Sticky <= 1'b0;
            r_s1Zero   <= 1'b0;
            r_s1MulUnf <= 1'b0;
            r_s1Rsvd   <= 1'b0;
        end else if (w_s1Load) begin
            r_s1Valid  <= bus.in_valid;
            r_s1Sign   <= bus.in_sign;
            r_s1Exp    <= w_normExp;
            r_s1Man    <= w_norm;
            r_s1Sticky <= w_shiftOut;
            r_s1Zero   <= !w_nonzero;
            r_s1MulUnf <= w_mulUnf;
            r_s1Rsvd   <= (bus.in_operator == 2'b11);
        end
    end

    assign w_kept    = r_s1Man[IN_W-3 -: MAN_W];
    assign w_guard   = r_s1Man[IN_W-3-MAN_W];
    assign w_sticky  = (|r_s1Man[IN_W-4-MAN_W:0]) | r_s1Sticky;
    assign w_inc     = ROUND_EN && w_guard && (w_sticky || w_kept[0]);
    assign w_inexact = ROUND_EN && (w_guard || w_sticky);
    assign w_sum     = {1'b0, w_kept} + (MAN_W+1)'(w_inc);
    assign w_rndExp  = r_s1Exp + (w_sum[MAN_W] ? EXP_ONE : EXP_ZERO);

    // Exceptions are judged on the post-rounding exponent; reserved and zero inputs win over both.
    always_comb begin
        w_sign  = r_s1Sign;
        w_exp   = w_rndExp[EXP_W-1:0];
        w_man   = w_sum[MAN_W-1:0];
        w_flags = {2'b00, w_inexact, 1'b0};
        if (r_s1Rsvd) begin
            w_sign  = 1'b0;
            w_exp   = '0;
            w_man   = '0;
            w_flags = 4'b0000;
        end else if (r_s1Zero) begin
            w_exp   = '0;
            w_man   = '0;
            w_flags = 4'b0001;
        end else if (w_rndExp >= EXP_MAX) begin
            w_exp   = '1;
            w_man   = '0;
            w_flags = {1'b1, 1'b0, ROUND_EN, 1'b0};
        end else if ((w_rndExp <= EXP_ZERO) || r_s1MulUnf) begin
            w_exp   = '0;
            w_man   = '0;
            w_flags = {1'b0, 1'b1, ROUND_EN, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_man      <= '0;
            r_flags    <= '0;
        end else if (w_s2Load) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_sign  <= w_sign;
                r_exp   <= w_exp;
                r_man   <= w_man;
                r_flags <= w_flags;
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.sign      = r_sign;
    assign bus.exponent  = r_exp;
    assign bus.mantissa  = r_man;
    assign bus.flags     = r_flags;
endmodule
